// File: rtl/cdc_sync_data_arbiter_if.sv
// cdc_sync_data_arbiter_if: requester/channel bundle for the source-domain arbiter.
//   req/req_data : per-requester level request and packed payloads (master drives)
//   grant        : one-hot grant pulse back to requesters (slave drives)
//   sync_enable, sync_bits : channel enable pulse and {id, payload} (slave drives)
//   busy         : holdoff counter running (slave drives)
interface cdc_sync_data_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 2
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           grant;
  logic                         sync_enable;
  logic [ID_BITS+DATA_BITS-1:0] sync_bits;
  logic                         busy;
  modport master (output req, req_data, input grant, sync_enable, sync_bits, busy);
  modport slave  (input req, req_data, output grant, sync_enable, sync_bits, busy);
endinterface

// File: rtl/cdc_sync_data_arbiter.sv
// cdc_sync_data_arbiter: round-robin scheduler pacing NUM_REQ requesters onto one CDC data channel.
//   clk_in_i  : source-domain clock
//   resetn_i  : asynchronous active-low reset
//   bus       : cdc_sync_data_arbiter_if.slave (req, req_data in; grant, sync_enable, sync_bits, busy out)
//   Define CDC_SYNC_ARB_PRIORITY_EN to give requester 0 strict priority without moving the pointer.
module cdc_sync_data_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = 2,
  parameter int HOLDOFF   = 4
) (
  input  logic                    clk_in_i,
  input  logic                    resetn_i,
  cdc_sync_data_arbiter_if.slave  bus
);
  localparam int CW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t                       state_q;
  logic [NUM_REQ-1:0]           grant_q;
  logic                         en_q;
  logic                         busy_q;
  logic [ID_BITS+DATA_BITS-1:0] bits_q;
  logic [ID_BITS-1:0]           rr_q;
  logic [CW-1:0]                cnt_q;
  logic [ID_BITS-1:0]           win_d;
  logic [ID_BITS-1:0]           rr_d;
  logic [DATA_BITS-1:0]         pay_d;
  logic                         upd_d;
  // Winner: lowest set bit at/after rr_q, falling back to the lowest set bit overall (wrap).
  always_comb begin
    win_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[k]) win_d = ID_BITS'(k);
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[k] && ID_BITS'(k) >= rr_q) win_d = ID_BITS'(k);
    upd_d = 1'b1;
`ifdef CDC_SYNC_ARB_PRIORITY_EN
    win_d = bus.req[0] ? '0 : win_d;
    upd_d = !bus.req[0];
`endif
    rr_d  = (int'(win_d) == NUM_REQ - 1) ? '0 : win_d + ID_BITS'(1);
    pay_d = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (win_d == ID_BITS'(k)) pay_d = bus.req_data[k*DATA_BITS +: DATA_BITS];
  end
  always_ff @(posedge clk_in_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      bits_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      grant_q <= '0;
      en_q    <= 1'b0;
      if (state_q == HOLD) begin
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (|bus.req) begin
        grant_q <= NUM_REQ'(1) << win_d;
        en_q    <= 1'b1;
        bits_q  <= {win_d, pay_d};
        if (upd_d) rr_q <= rr_d;
        // HOLDOFF==1 never leaves IDLE, giving back-to-back launches.
        if (HOLDOFF > 1) begin
          cnt_q   <= CW'(HOLDOFF - 1);
          state_q <= HOLD;
          busy_q  <= 1'b1;
        end
      end
    end
  end
  assign bus.grant       = grant_q;
  assign bus.sync_enable = en_q;
  assign bus.sync_bits   = bits_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_cdc_sync_data_arbiter.sv
// tb_cdc_sync_data_arbiter: random + directed checks of two arbiter instances (HOLDOFF 4 and 1) against a queue-free behavioural model.
module tb_cdc_sync_data_arbiter;
`ifdef CDC_SYNC_ARB_PRIORITY_EN
  localparam bit PRI = 1'b1;
`else
  localparam bit PRI = 1'b0;
`endif
  logic         clk_in = 1'b0;
  logic         resetn;
  logic [3:0]   req;
  logic [127:0] req_data;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk_in = ~clk_in;
  cdc_sync_data_arbiter_if #(.NUM_REQ(4), .DATA_BITS(32), .ID_BITS(2)) if_a ();
  cdc_sync_data_arbiter_if #(.NUM_REQ(4), .DATA_BITS(32), .ID_BITS(2)) if_b ();
  assign if_a.req      = req;
  assign if_a.req_data = req_data;
  assign if_b.req      = req;
  assign if_b.req_data = req_data;
  cdc_sync_data_arbiter #(.NUM_REQ(4), .DATA_BITS(32), .ID_BITS(2), .HOLDOFF(4)) u_a (
    .clk_in_i(clk_in), .resetn_i(resetn), .bus(if_a.slave));
  cdc_sync_data_arbiter #(.NUM_REQ(4), .DATA_BITS(32), .ID_BITS(2), .HOLDOFF(1)) u_b (
    .clk_in_i(clk_in), .resetn_i(resetn), .bus(if_b.slave));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int hold_of(input int k);
    return k == 0 ? 4 : 1;
  endfunction
  function automatic int pick(input int ptr, input logic [3:0] r);
    logic [1:0] idx;
    if (PRI && r[0]) return 0;
    for (int o = 0; o < 4; o++) begin
      idx = 2'((ptr + o) % 4);
      if (r[idx]) return int'(idx);
    end
    return 0;
  endfunction
  // Model: a launch is allowed when the wait count is zero; each launch blocks the next holdoff-1 cycles.
  logic [3:0]  m_grant [2];
  logic        m_en    [2];
  logic        m_busy  [2];
  logic [33:0] m_bits  [2];
  int          m_ptr   [2];
  int          m_wait  [2];
  always @(posedge clk_in or negedge resetn) begin
    int w;
    if (!resetn) begin
      for (int k = 0; k < 2; k++) begin
        m_grant[k] <= '0; m_en[k] <= 1'b0; m_busy[k] <= 1'b0;
        m_bits[k] <= '0; m_ptr[k] <= 0; m_wait[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_grant[k] <= '0;
        m_en[k]    <= 1'b0;
        if (m_wait[k] > 0) begin
          m_wait[k] <= m_wait[k] - 1;
          m_busy[k] <= m_wait[k] > 1;
        end else if (req != 4'b0) begin
          w = pick(m_ptr[k], req);
          m_grant[k] <= 4'(1 << w);
          m_en[k]    <= 1'b1;
          m_bits[k]  <= {2'(w), 32'(req_data >> (32 * w))};
          if (!(PRI && req[0])) m_ptr[k] <= (w + 1) % 4;
          m_wait[k]  <= hold_of(k) - 1;
          m_busy[k]  <= hold_of(k) > 1;
        end
      end
    end
  end
  always @(negedge clk_in) begin
    chk("a.grant", 64'(if_a.grant), 64'(m_grant[0]));
    chk("a.sync_enable", 64'(if_a.sync_enable), 64'(m_en[0]));
    chk("a.sync_bits", 64'(if_a.sync_bits), 64'(m_bits[0]));
    chk("a.busy", 64'(if_a.busy), 64'(m_busy[0]));
    chk("b.grant", 64'(if_b.grant), 64'(m_grant[1]));
    chk("b.sync_enable", 64'(if_b.sync_enable), 64'(m_en[1]));
    chk("b.sync_bits", 64'(if_b.sync_bits), 64'(m_bits[1]));
    chk("b.busy", 64'(if_b.busy), 64'(m_busy[1]));
  end
  initial begin
    resetn = 1'b0;
    req = 4'b1111;
    req_data = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      @(negedge clk_in);
      chk("rst.grant", 64'(if_a.grant), 64'(0));
      chk("rst.en", 64'(if_a.sync_enable), 64'(0));
      chk("rst.bits", 64'(if_a.sync_bits), 64'(0));
      chk("rst.busy", 64'(if_a.busy), 64'(0));
    end
    req = 4'b0100;
    req_data[64 +: 32] = 32'hA5A5_0002;
    resetn = 1'b1;
    @(negedge clk_in);
    chk("one.grant", 64'(if_a.grant), 64'(4'b0100));
    chk("one.en", 64'(if_a.sync_enable), 64'(1));
    chk("one.bits", 64'(if_a.sync_bits), 64'({2'd2, 32'hA5A5_0002}));
    chk("one.model_grant", 64'(m_grant[0]), 64'(4'b0100));
    chk("one.busy", 64'(if_a.busy), 64'(1));
    req = 4'b0000;
    repeat (2) begin
      @(negedge clk_in);
      chk("one.busy_hold", 64'(if_a.busy), 64'(1));
      chk("one.no_pulse", 64'(if_a.sync_enable), 64'(0));
    end
    repeat (4) begin
      @(negedge clk_in);
      chk("one.busy_done", 64'(if_a.busy), 64'(0));
      chk("one.no_pulse", 64'(if_a.sync_enable), 64'(0));
      chk("one.bits_held", 64'(if_a.sync_bits), 64'({2'd2, 32'hA5A5_0002}));
    end
    resetn = 1'b0;
    @(negedge clk_in);
    req = 4'b1111;
    resetn = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_in);
      chk("rot4.grant", 64'(if_a.grant), 64'((c % 4 == 1) ? (PRI ? 1 : 1 << ((c - 1) / 4)) : 0));
      chk("rot4.en", 64'(if_a.sync_enable), 64'(c % 4 == 1));
      chk("rot1.grant", 64'(if_b.grant), 64'(PRI ? 1 : 1 << ((c - 1) % 4)));
      chk("rot1.en", 64'(if_b.sync_enable), 64'(1));
    end
    resetn = 1'b0;
    @(negedge clk_in);
    req = 4'b0011;
    resetn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_in);
      chk("alt.grant", 64'(if_b.grant), 64'(PRI ? 1 : 1 << ((c - 1) % 2)));
      chk("alt.en", 64'(if_b.sync_enable), 64'(1));
    end
    resetn = 1'b0;
    @(negedge clk_in);
    req = 4'b1111;
    resetn = 1'b1;
    repeat (10) @(negedge clk_in);
    chk("midhold.busy_before", 64'(if_a.busy), 64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("midhold.busy", 64'(if_a.busy), 64'(0));
    chk("midhold.grant", 64'(if_a.grant), 64'(0));
    @(negedge clk_in);
    req = 4'b1010;
    resetn = 1'b1;
    @(negedge clk_in);
    chk("midhold.regrant", 64'(if_a.grant), 64'(4'b0010));
    chk("midhold.id", 64'(if_a.sync_bits[33:32]), 64'(1));
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if ($urandom % 4 == 0) req[i] = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req[i] = 1'b1;
          req_data[i*32 +: 32] = $urandom;
        end
      end
      resetn = ($urandom % 700) != 0;
    end
    resetn = 1'b1;
    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
